// File: rtl/axi_rd_burst_splitter.sv
// axi_rd_burst_splitter
//   AXI4 read-path burst splitter. Upstream INCR bursts longer than MaxBeats
//   are reissued downstream as chained sub-bursts. Each sub-burst ends on a
//   MaxBeats*2^size byte boundary or on the last beat, so the first one may be
//   short. The downstream R beats are merged back into one burst per upstream
//   AR by suppressing r_last on all sub-bursts except the final one. FIXED,
//   WRAP, exclusive (lock) and short INCR bursts are forwarded unchanged.
//
//   Ports
//     clk_i, rst_ni      clock, async active-low reset
//     s_ar_*             upstream AR channel (slave side), s_ar_ready_o out
//     s_r_*              upstream R channel, s_r_ready_i in
//     m_ar_*             downstream AR channel (master side), registered
//     m_r_*              downstream R channel, m_r_ready_o out
//     busy_o             at least one upstream read is outstanding
//     split_cnt_o        saturating count of upstream ARs that were split
//
//   Build option
//     RD_SPLIT_PERF_EN   when defined, split_cnt_o is a live counter;
//                        otherwise it is tied to zero.
module axi_rd_burst_splitter #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned UserWidth = 1,
  parameter int unsigned MaxBeats  = 16,
  parameter int unsigned MaxTxns   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  // upstream AR
  input  logic [IdWidth-1:0]   s_ar_id_i,
  input  logic [AddrWidth-1:0] s_ar_addr_i,
  input  logic [7:0]           s_ar_len_i,
  input  logic [2:0]           s_ar_size_i,
  input  logic [1:0]           s_ar_burst_i,
  input  logic                 s_ar_lock_i,
  input  logic [3:0]           s_ar_cache_i,
  input  logic [2:0]           s_ar_prot_i,
  input  logic [3:0]           s_ar_qos_i,
  input  logic [3:0]           s_ar_region_i,
  input  logic [UserWidth-1:0] s_ar_user_i,
  input  logic                 s_ar_valid_i,
  output logic                 s_ar_ready_o,
  // upstream R
  output logic [IdWidth-1:0]   s_r_id_o,
  output logic [DataWidth-1:0] s_r_data_o,
  output logic [1:0]           s_r_resp_o,
  output logic                 s_r_last_o,
  output logic [UserWidth-1:0] s_r_user_o,
  output logic                 s_r_valid_o,
  input  logic                 s_r_ready_i,
  // downstream AR
  output logic [IdWidth-1:0]   m_ar_id_o,
  output logic [AddrWidth-1:0] m_ar_addr_o,
  output logic [7:0]           m_ar_len_o,
  output logic [2:0]           m_ar_size_o,
  output logic [1:0]           m_ar_burst_o,
  output logic                 m_ar_lock_o,
  output logic [3:0]           m_ar_cache_o,
  output logic [2:0]           m_ar_prot_o,
  output logic [3:0]           m_ar_qos_o,
  output logic [3:0]           m_ar_region_o,
  output logic [UserWidth-1:0] m_ar_user_o,
  output logic                 m_ar_valid_o,
  input  logic                 m_ar_ready_i,
  // downstream R
  input  logic [IdWidth-1:0]   m_r_id_i,
  input  logic [DataWidth-1:0] m_r_data_i,
  input  logic [1:0]           m_r_resp_i,
  input  logic                 m_r_last_i,
  input  logic [UserWidth-1:0] m_r_user_i,
  input  logic                 m_r_valid_i,
  output logic                 m_r_ready_o,
  // status
  output logic                 busy_o,
  output logic [31:0]          split_cnt_o
);

  localparam int unsigned BeatLog = $clog2(MaxBeats);
  localparam int unsigned PtrW    = (MaxTxns > 1) ? $clog2(MaxTxns) : 1;
  localparam int unsigned OccW    = $clog2(MaxTxns + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic                 lock;
    logic [3:0]           cache;
    logic [2:0]           prot;
    logic [3:0]           qos;
    logic [3:0]           region;
    logic [UserWidth-1:0] user;
  } ar_attr_t;

  logic [0:0]           state_q, state_d;
  logic                 init_q;
  ar_attr_t             attr_q, attr_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [7:0]           len_q, len_d;
  logic [8:0]           rem_q, rem_d;     // beats not yet issued after the current sub-burst
  logic [IdWidth-1:0]   out_id_q, out_id_d;

  // per-upstream-txn count of sub-bursts whose R last is still due
  logic [8:0]           cnt_q [MaxTxns];
  logic [8:0]           cnt_d [MaxTxns];
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [OccW-1:0]      occ_q, occ_d;

  logic                 fifo_full, fifo_empty, accept, r_last_hs, pop;
  logic [8:0]           head_cnt;
  logic [8:0]           s_beats, s_to_bnd, s_first, s_nsub, nxt_sub;
  logic [BeatLog-1:0]   s_off;
  logic [9:0]           s_span;
  logic                 s_split;
  logic [AddrWidth-1:0] step;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxTxns - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_full  = (occ_q == OccW'(MaxTxns));
  assign fifo_empty = (occ_q == '0);
  assign head_cnt   = cnt_q[rd_ptr_q];
  assign busy_o     = !fifo_empty;

  // Same-id restriction: downstream returns in AR order only within one id.
  assign s_ar_ready_o = init_q && (state_q == ST_IDLE) && !fifo_full &&
                        (fifo_empty || (s_ar_id_i == out_id_q));
  assign accept       = s_ar_valid_i && s_ar_ready_o;

  // First sub-burst geometry for the incoming AR.
  assign s_beats  = {1'b0, s_ar_len_i} + 9'd1;
  assign s_split  = (s_ar_burst_i == BURST_INCR) && !s_ar_lock_i && (s_beats > 9'(MaxBeats));
  assign s_off    = BeatLog'(s_ar_addr_i >> s_ar_size_i);
  assign s_to_bnd = 9'(MaxBeats) - 9'(s_off);
  assign s_first  = s_split ? s_to_bnd : s_beats;
  assign s_span   = 10'(s_off) + {1'b0, s_beats} + 10'(MaxBeats - 1);
  assign s_nsub   = s_split ? 9'(s_span >> BeatLog) : 9'd1;

  // After the first sub-burst the address is boundary aligned.
  assign step    = AddrWidth'({1'b0, len_q} + 9'd1) << attr_q.size;
  assign nxt_sub = (rem_q > 9'(MaxBeats)) ? 9'(MaxBeats) : rem_q;

  assign r_last_hs = m_r_valid_i && s_r_ready_i && m_r_last_i && !fifo_empty;
  assign pop       = r_last_hs && (head_cnt == 9'd1);

  always_comb begin
    state_d  = state_q;
    attr_d   = attr_q;
    addr_d   = addr_q;
    len_d    = len_q;
    rem_d    = rem_q;
    out_id_d = out_id_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        attr_d   = '{s_ar_id_i, s_ar_size_i, s_ar_burst_i, s_ar_lock_i, s_ar_cache_i,
                     s_ar_prot_i, s_ar_qos_i, s_ar_region_i, s_ar_user_i};
        addr_d   = s_ar_addr_i;
        len_d    = 8'(s_first - 9'd1);
        rem_d    = s_beats - s_first;
        out_id_d = s_ar_id_i;
        state_d  = ST_ISSUE;
      end
      default: if (m_ar_ready_i) begin
        if (rem_q != '0) begin
          addr_d = addr_q + step;
          len_d  = 8'(nxt_sub - 9'd1);
          rem_d  = rem_q - nxt_sub;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    // push and head update never target the same slot: push needs a free
    // slot, head update needs a non-empty FIFO
    if (r_last_hs) cnt_d[rd_ptr_q] = head_cnt - 9'd1;
    if (accept) begin
      cnt_d[wr_ptr_q] = s_nsub;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    occ_d = occ_q + OccW'(accept) - OccW'(pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      init_q   <= 1'b0;
      attr_q   <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      rem_q    <= '0;
      out_id_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      for (int i = 0; i < MaxTxns; i++) cnt_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      init_q   <= 1'b1;
      attr_q   <= attr_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      rem_q    <= rem_d;
      out_id_q <= out_id_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      cnt_q    <= cnt_d;
    end
  end

  assign m_ar_valid_o  = (state_q == ST_ISSUE);
  assign m_ar_id_o     = attr_q.id;
  assign m_ar_addr_o   = addr_q;
  assign m_ar_len_o    = len_q;
  assign m_ar_size_o   = attr_q.size;
  assign m_ar_burst_o  = attr_q.burst;
  assign m_ar_lock_o   = attr_q.lock;
  assign m_ar_cache_o  = attr_q.cache;
  assign m_ar_prot_o   = attr_q.prot;
  assign m_ar_qos_o    = attr_q.qos;
  assign m_ar_region_o = attr_q.region;
  assign m_ar_user_o   = attr_q.user;

  assign s_r_valid_o = m_r_valid_i;
  assign m_r_ready_o = s_r_ready_i;
  assign s_r_id_o    = m_r_id_i;
  assign s_r_data_o  = m_r_data_i;
  assign s_r_resp_o  = m_r_resp_i;
  assign s_r_user_o  = m_r_user_i;
  assign s_r_last_o  = m_r_last_i && !fifo_empty && (head_cnt == 9'd1);

`ifdef RD_SPLIT_PERF_EN
  logic [31:0] split_cnt_q, split_cnt_d;
  always_comb begin
    split_cnt_d = split_cnt_q;
    if (accept && (s_nsub > 9'd1) && (split_cnt_q != '1)) split_cnt_d = split_cnt_q + 32'd1;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) split_cnt_q <= '0;
    else         split_cnt_q <= split_cnt_d;
  end
  assign split_cnt_o = split_cnt_q;
`else
  assign split_cnt_o = '0;
`endif

endmodule

// File: tb/tb_axi_rd_burst_splitter.sv
// Bench for axi_rd_burst_splitter: directed upstream ARs, a behavioural
// downstream slave, and scoreboards for the expected downstream ARs and the
// expected upstream R beats (built from a per-beat boundary model).
module tb_axi_rd_burst_splitter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  s_ar_id; logic [63:0] s_ar_addr; logic [7:0] s_ar_len; logic [2:0] s_ar_size;
  logic [1:0]  s_ar_burst; logic s_ar_lock; logic s_ar_valid; logic s_ar_ready;
  logic [3:0]  s_r_id; logic [63:0] s_r_data; logic [1:0] s_r_resp; logic s_r_last;
  logic [0:0]  s_r_user; logic s_r_valid; logic s_r_ready;
  logic [3:0]  m_ar_id; logic [63:0] m_ar_addr; logic [7:0] m_ar_len; logic [2:0] m_ar_size;
  logic [1:0]  m_ar_burst; logic m_ar_lock; logic [3:0] m_ar_cache, m_ar_qos, m_ar_region;
  logic [2:0]  m_ar_prot; logic [0:0] m_ar_user; logic m_ar_valid; logic m_ar_ready;
  logic [3:0]  m_r_id; logic [63:0] m_r_data; logic [1:0] m_r_resp; logic m_r_last;
  logic m_r_valid; logic m_r_ready; logic busy; logic [31:0] split_cnt;

  axi_rd_burst_splitter dut (
    .clk_i(clk), .rst_ni(rst_n),
    .s_ar_id_i(s_ar_id), .s_ar_addr_i(s_ar_addr), .s_ar_len_i(s_ar_len), .s_ar_size_i(s_ar_size),
    .s_ar_burst_i(s_ar_burst), .s_ar_lock_i(s_ar_lock), .s_ar_cache_i(4'h3), .s_ar_prot_i(3'h0),
    .s_ar_qos_i(4'h0), .s_ar_region_i(4'h0), .s_ar_user_i(1'b0),
    .s_ar_valid_i(s_ar_valid), .s_ar_ready_o(s_ar_ready),
    .s_r_id_o(s_r_id), .s_r_data_o(s_r_data), .s_r_resp_o(s_r_resp), .s_r_last_o(s_r_last),
    .s_r_user_o(s_r_user), .s_r_valid_o(s_r_valid), .s_r_ready_i(s_r_ready),
    .m_ar_id_o(m_ar_id), .m_ar_addr_o(m_ar_addr), .m_ar_len_o(m_ar_len), .m_ar_size_o(m_ar_size),
    .m_ar_burst_o(m_ar_burst), .m_ar_lock_o(m_ar_lock), .m_ar_cache_o(m_ar_cache),
    .m_ar_prot_o(m_ar_prot), .m_ar_qos_o(m_ar_qos), .m_ar_region_o(m_ar_region),
    .m_ar_user_o(m_ar_user), .m_ar_valid_o(m_ar_valid), .m_ar_ready_i(m_ar_ready),
    .m_r_id_i(m_r_id), .m_r_data_i(m_r_data), .m_r_resp_i(m_r_resp), .m_r_last_i(m_r_last),
    .m_r_user_i(1'b0), .m_r_valid_i(m_r_valid), .m_r_ready_o(m_r_ready),
    .busy_o(busy), .split_cnt_o(split_cnt)
  );

  typedef struct packed { logic [63:0] addr; logic [7:0] len; logic [3:0] id; } ar_t;
  typedef struct packed { logic [3:0] id; logic last; } rb_t;

  ar_t exp_ar[$];
  rb_t exp_r[$];
  ar_t pend[$];
  int  checks = 0, fails = 0, split_model = 0, beat = 0;
  logic [63:0] up_cnt = '0, dn_cnt = '0;
  logic r_en, r_hs;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_split();
`ifdef RD_SPLIT_PERF_EN
    return split_model;
`else
    return 0;
`endif
  endfunction

  function automatic logic [1:0] resp_of(input logic [63:0] n);
    return (n % 7 == 5) ? 2'b10 : 2'b00;
  endfunction

  // Beat-by-beat reference: a new sub-burst starts when the beat address hits
  // a 16*2^size boundary.
  task automatic model_ar(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic lock, input logic [3:0] id);
    int nsub = 0, n = 0;
    logic [63:0] a, start, win;
    if (burst == 2'b01 && !lock && int'(len) + 1 > 16) begin
      a = addr; start = addr; win = 64'd16 << size;
      for (int i = 0; i <= int'(len); i++) begin
        if (n > 0 && (a % win) == 0) begin
          exp_ar.push_back('{start, 8'(n - 1), id}); nsub++; start = a; n = 0;
        end
        n++; a += 64'd1 << size;
      end
      exp_ar.push_back('{start, 8'(n - 1), id}); nsub++;
    end else begin
      exp_ar.push_back('{addr, len, id}); nsub = 1;
    end
    if (nsub > 1) split_model++;
    for (int i = 0; i <= int'(len); i++) exp_r.push_back('{id, i == int'(len)});
  endtask

  // monitor + downstream slave
  initial begin
    ar_t e; rb_t er;
    m_r_valid = 0; m_r_last = 0; m_r_id = 0; m_r_data = 0; m_r_resp = 0; r_hs = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_ar.delete(); exp_r.delete(); pend.delete();
        beat = 0; dn_cnt = '0; up_cnt = '0; r_hs = 0; split_model = 0;
      end else begin
        if (s_ar_valid && s_ar_ready)
          model_ar(s_ar_addr, s_ar_len, s_ar_size, s_ar_burst, s_ar_lock, s_ar_id);
        if (m_ar_valid && m_ar_ready) begin
          if (exp_ar.size() == 0) chk("m_ar_unexpected", 1, 0);
          else begin
            e = exp_ar.pop_front();
            chk("m_ar", {m_ar_addr, m_ar_len, m_ar_id}, e);
          end
          pend.push_back('{m_ar_addr, m_ar_len, m_ar_id});
        end
        r_hs = m_r_valid && m_r_ready;
        if (s_r_valid && s_r_ready) begin
          if (exp_r.size() == 0) chk("r_unexpected", 1, 0);
          else begin
            er = exp_r.pop_front();
            chk("r_beat", {s_r_id, s_r_last, s_r_resp, s_r_data},
                          {er.id, er.last, resp_of(up_cnt), up_cnt});
            up_cnt++;
          end
        end
      end
      @(posedge clk); #2;
      if (!rst_n) m_r_valid = 0;
      else begin
        if (r_hs) begin
          dn_cnt++;
          if (beat == int'(pend[0].len)) begin void'(pend.pop_front()); beat = 0; end
          else beat++;
        end
        if (r_en && pend.size() > 0) begin
          m_r_valid = 1; m_r_id = pend[0].id; m_r_data = dn_cnt;
          m_r_resp = resp_of(dn_cnt); m_r_last = (beat == int'(pend[0].len));
        end else m_r_valid = 0;
      end
    end
  end

  // caller is at posedge+#1; returns at posedge+#1 after the handshake edge
  task automatic send_ar(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic lock,
                         output logic busy_acc, output logic rlast_acc);
    bit ok = 0;
    s_ar_id = id; s_ar_addr = addr; s_ar_len = len; s_ar_size = 3'd3;
    s_ar_burst = burst; s_ar_lock = lock; s_ar_valid = 1;
    busy_acc = 0; rlast_acc = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (s_ar_ready) begin
        ok = 1; busy_acc = busy; rlast_acc = m_r_valid && m_r_ready && s_r_last; break;
      end
    end
    if (!ok) chk("ar_accept_timeout", 0, 1);
    @(posedge clk); #1;
    s_ar_valid = 0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy && !m_ar_valid && exp_ar.size() == 0 && exp_r.size() == 0) begin ok = 1; break; end
    end
    chk("idle_reached", ok, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic b, rl;
    s_ar_valid = 0; s_ar_id = 0; s_ar_addr = 0; s_ar_len = 0; s_ar_size = 3;
    s_ar_burst = 1; s_ar_lock = 0; s_r_ready = 1; m_ar_ready = 1; r_en = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_ar_valid", m_ar_valid, 0);
    chk("rst_s_ar_ready", s_ar_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_split_cnt", split_cnt, 0);
    @(posedge clk); #1 rst_n = 1;
    repeat (2) @(posedge clk); #1;

    // long INCR: 4 aligned sub-bursts of 16
    send_ar(4'd1, 64'h1000, 8'd63, 2'b01, 0, b, rl);
    wait_idle();
    // unaligned start: short first sub-burst
    send_ar(4'd1, 64'h1040, 8'd19, 2'b01, 0, b, rl);
    wait_idle();
    chk("split_cnt_two", split_cnt, exp_split());
    // WRAP, short INCR crossing a boundary, exclusive long INCR: all unsplit
    send_ar(4'd4, 64'h2000, 8'd15, 2'b10, 0, b, rl);
    send_ar(4'd4, 64'h3040, 8'd15, 2'b01, 0, b, rl);
    send_ar(4'd4, 64'h7000, 8'd31, 2'b01, 1, b, rl);
    wait_idle();
    chk("split_cnt_unsplit", split_cnt, exp_split());

    // FIFO full: 4 outstanding id=2, 5th stalls until the first final beat
    r_en = 0;
    for (int i = 0; i < 4; i++) send_ar(4'd2, 64'h5000 + 64'(i) * 64'h100, 8'd3, 2'b01, 0, b, rl);
    repeat (3) @(posedge clk); #1;
    s_ar_id = 4'd2; s_ar_addr = 64'h5400; s_ar_len = 8'd3; s_ar_burst = 2'b01; s_ar_lock = 0;
    s_ar_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("full_stall_ready", s_ar_ready, 0);
      chk("full_busy", busy, 1);
    end
    @(posedge clk); #1 r_en = 1;
    send_ar(4'd2, 64'h5400, 8'd3, 2'b01, 0, b, rl);
    // different id waits for the pipe to drain
    s_ar_id = 4'd5; s_ar_valid = 1;
    @(negedge clk);
    chk("id_stall_ready", s_ar_ready, 0);
    @(posedge clk); #1;
    send_ar(4'd5, 64'h9000, 8'd7, 2'b01, 0, b, rl);
    chk("id_accept_not_busy", b, 0);
    wait_idle();

    // back-pressured split: payload must hold
    m_ar_ready = 0;
    send_ar(4'd6, 64'h4000, 8'd47, 2'b01, 0, b, rl);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", m_ar_valid, 1);
      chk("hold_payload", {m_ar_addr, m_ar_len}, {exp_ar[0].addr, exp_ar[0].len});
    end
    @(posedge clk); #1 m_ar_ready = 1;
    wait_idle();
    chk("split_cnt_three", split_cnt, exp_split());

    // final R pop in the same cycle as a new accept
    r_en = 0;
    send_ar(4'd3, 64'h6000, 8'd0, 2'b01, 0, b, rl);
    repeat (3) @(posedge clk); #1;
    r_en = 1;
    send_ar(4'd3, 64'h6100, 8'd3, 2'b01, 0, b, rl);
    chk("push_pop_same_cycle", rl, 1);
    chk("push_pop_busy", busy, 1);
    wait_idle();

    // reset in the middle of a split
    send_ar(4'd7, 64'h8000, 8'd63, 2'b01, 0, b, rl);
    repeat (6) @(posedge clk); #1 rst_n = 0;
    @(negedge clk);
    chk("mid_rst_m_ar_valid", m_ar_valid, 0);
    chk("mid_rst_s_ar_ready", s_ar_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_split_cnt", split_cnt, 0);
    @(posedge clk); #1 rst_n = 1;
    repeat (2) @(posedge clk); #1;
    send_ar(4'd8, 64'h1040, 8'd19, 2'b01, 0, b, rl);
    wait_idle();
    chk("post_rst_split_cnt", split_cnt, exp_split());

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
